ahb_sram_subordinate: RTL and testbench

- AHB-Lite subordinate (responder) that sits on the far side of the multi-manager mainbus: decodes granted transfers, stores them in a word-addressed SRAM and returns HRDATA, HREADYOUT and HRESP.
- Supports byte, halfword and word accesses, programmable wait states, and the two-cycle ERROR response.
- Serves as the reference memory target for mainbus bring-up and arbitration tests.

---
 rtl/ahb_sram_subordinate_if.sv | 26 ++
 rtl/ahb_sram_subordinate.sv | 125 ++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_subordinate_if.sv
// rtl/ahb_sram_subordinate_if.sv - AHB-Lite bus bundle between a manager and the SRAM subordinate
interface ahb_sram_subordinate_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB-Lite SRAM target with wait states, ERROR response and RAW forwarding
module ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_sram_subordinate_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] a_idx;
    logic [3:0]       a_lane;
    logic             a_write;

    logic [31:0]      mem [DEPTH];

    logic             acc;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_hit;
    logic [31:0]      rd_word;
    logic             unused_ok;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign acc     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign acc_idx = bus.HADDR[IDX_W+1:2];
    assign acc_err = (bus.HSIZE > 3'b010)
                   | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                   | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]))
                   | (|bus.HADDR[ADDR_WIDTH-1:IDX_W+2]);

    // A read launched straight into DATA must see the lanes the current write commits this edge.
    assign rd_idx = (state == S_WAIT) ? a_idx : acc_idx;
    assign wr_hit = (state == S_DATA) && a_write && (a_idx == rd_idx);

    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_hit && a_lane[i]) begin
                rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= S_IDLE;
            cnt           <= '0;
            a_idx         <= '0;
            a_lane        <= '0;
            a_write       <= 1'b0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
            bus.HRDATA    <= '0;
        end else begin
            bus.HRDATA <= '0;
            if (state == S_WAIT) begin
                if (cnt == 4'd0) begin
                    state         <= S_DATA;
                    bus.HREADYOUT <= 1'b1;
                    if (!a_write) begin
                        bus.HRDATA <= rd_word;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (state == S_ERR1) begin
                state         <= S_ERR2;
                bus.HREADYOUT <= 1'b1;
                bus.HRESP     <= 1'b1;
            end else if (acc) begin
                a_idx   <= acc_idx;
                a_lane  <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
                a_write <= bus.HWRITE;
                if (acc_err) begin
                    state         <= S_ERR1;
                    bus.HREADYOUT <= 1'b0;
                    bus.HRESP     <= 1'b1;
                end else if (WAIT_STATES > 0) begin
                    state         <= S_WAIT;
                    cnt           <= 4'(WAIT_STATES - 1);
                    bus.HREADYOUT <= 1'b0;
                    bus.HRESP     <= 1'b0;
                end else begin
                    state         <= S_DATA;
                    bus.HREADYOUT <= 1'b1;
                    bus.HRESP     <= 1'b0;
                    if (!bus.HWRITE) begin
                        bus.HRDATA <= rd_word;
                    end
                end
            end else begin
                state         <= S_IDLE;
                bus.HREADYOUT <= 1'b1;
                bus.HRESP     <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && a_write) begin
            for (int i = 0; i < 4; i++) begin
                if (a_lane[i]) begin
                    mem[a_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb/tb_ahb_sram_subordinate.sv - randomized bench for ahb_sram_subordinate against a byte-level memory model
module tb_ahb_sram_subordinate;
    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        hsel   [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];

    logic [7:0]  mb [2][1024];
    xfer_t       tq[$];
    int          n_pass = 0;
    int          n_chk  = 0;

    always #5 clk = ~clk;

    ahb_sram_subordinate_if #(.ADDR_WIDTH(32)) if0 ();
    ahb_sram_subordinate_if #(.ADDR_WIDTH(32)) if1 ();

    assign if0.HSEL = hsel[0];  assign if0.HTRANS = htrans[0]; assign if0.HWRITE = hwrite[0];
    assign if0.HSIZE = hsize[0]; assign if0.HBURST = hburst[0]; assign if0.HADDR = haddr[0];
    assign if0.HWDATA = hwdata[0]; assign if0.HREADY = if0.HREADYOUT;
    assign if1.HSEL = hsel[1];  assign if1.HTRANS = htrans[1]; assign if1.HWRITE = hwrite[1];
    assign if1.HSIZE = hsize[1]; assign if1.HBURST = hburst[1]; assign if1.HADDR = haddr[1];
    assign if1.HWDATA = hwdata[1]; assign if1.HREADY = if1.HREADYOUT;

    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst[0]), .bus(if0.slave));
    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst[1]), .bus(if1.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [33:0] obs(input int d);
        if (d == 0) return {if0.HREADYOUT, if0.HRESP, if0.HRDATA};
        return {if1.HREADYOUT, if1.HRESP, if1.HRDATA};
    endfunction

    function automatic bit is_err(input xfer_t x);
        return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
               (x.size == 3'd2 && x.addr[1:0] != 2'd0) || ((x.addr >> 2) >= 32'd256);
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [31:0] a);
        int b;
        b = int'(a & 32'hFFFF_FFFC);
        return {mb[d][b+3], mb[d][b+2], mb[d][b+1], mb[d][b]};
    endfunction

    task automatic mwrite(input int d, input xfer_t x);
        int a;
        for (int k = 0; k < (1 << x.size); k++) begin
            a = int'(x.addr) + k;
            mb[d][a] = x.wdata[8*(a % 4) +: 8];
        end
    endtask

    task automatic drive(input int d, input xfer_t x);
        hsel[d]   = x.sel;
        htrans[d] = x.trans;
        hwrite[d] = x.wr;
        hsize[d]  = x.size;
        haddr[d]  = x.addr;
        hburst[d] = 3'($urandom_range(7));
    endtask

    function automatic xfer_t mk(input bit [1:0] tr, input bit wr, input bit [2:0] sz,
                                 input bit [31:0] a, input bit [31:0] wd);
        xfer_t x;
        x.sel = 1'b1; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
        return x;
    endfunction

    function automatic xfer_t rnd_xfer();
        xfer_t x;
        int r;
        x.sel = ($urandom_range(9) != 0);
        r = $urandom_range(9);
        x.trans = (r < 5) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
        x.wr = 1'($urandom_range(1));
        r = $urandom_range(9);
        x.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(7, 3));
        x.addr = 32'h40 + 32'($urandom_range(7)) * 4;
        if (x.size == 3'd0) x.addr += 32'($urandom_range(3));
        if (x.size == 3'd1) x.addr += 32'($urandom_range(1)) * 2;
        if ($urandom_range(9) == 0) x.addr = (x.addr & 32'hFFFF_FFFC) + 32'($urandom_range(3));
        if ($urandom_range(14) == 0) x.addr = 32'h400 + 32'($urandom_range(255));
        x.wdata = $urandom;
        return x;
    endfunction

    // Manager model: holds the address phase while HREADY is low and checks every data-phase cycle.
    task automatic run(input int d);
        xfer_t dp, idle;
        bit    dp_v, r;
        int    dp_n, i, guard, ws;
        logic [33:0] exp;
        idle = '{default: '0};
        ws = (d == 0) ? 0 : 3;
        i = 0; dp_v = 0; dp_n = 0; guard = 0;
        while ((i < tq.size() || dp_v) && guard < 5000) begin
            drive(d, (i < tq.size()) ? tq[i] : idle);
            hwdata[d] = dp_v ? dp.wdata : $urandom;
            @(negedge clk);
            if (!dp_v) exp = {1'b1, 1'b0, 32'h0};
            else if (is_err(dp)) exp = {(dp_n != 0), 1'b1, 32'h0};
            else if (dp_n < ws) exp = {1'b0, 1'b0, 32'h0};
            else exp = {1'b1, 1'b0, dp.wr ? 32'h0 : mread(d, dp.addr)};
            check($sformatf("bus d%0d a=%h", d, dp.addr), 64'(obs(d)), 64'(exp));
            r = obs(d)[33];
            @(posedge clk); #1;
            if (r) begin
                if (dp_v && !is_err(dp) && dp.wr) mwrite(d, dp);
                dp_v = 0;
                if (i < tq.size()) begin
                    if (tq[i].sel && tq[i].trans[1]) begin
                        dp = tq[i];
                        dp_v = 1;
                    end
                    i++;
                end
                dp_n = 0;
            end else begin
                dp_n++;
            end
            guard++;
        end
        check($sformatf("run_bound d%0d", d), 64'(guard < 5000), 64'd1);
        drive(d, idle);
        tq.delete();
    endtask

    initial begin
        xfer_t idle, w;
        idle = '{default: '0};
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            drive(d, idle);
            hwdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset d0", 64'(obs(0)), {30'h0, 34'h2_0000_0000});
        check("reset d1", 64'(obs(1)), {30'h0, 34'h2_0000_0000});
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 256; k++) tq.push_back(mk(2'b10, 1, 3'd2, 32'(k * 4), $urandom));
            run(d);

            tq.push_back(mk(2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h10, 32'h0));
            tq.push_back(mk(2'b10, 1, 3'd2, 32'h10, 32'h11223344));
            tq.push_back(mk(2'b10, 1, 3'd0, 32'h13, 32'hAA5A5A5A));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h10, 32'h0));
            tq.push_back(mk(2'b10, 1, 3'd1, 32'h10, 32'h77775566));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h10, 32'h0));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h20, 32'h0));
            tq.push_back(mk(2'b11, 0, 3'd2, 32'h24, 32'h0));
            tq.push_back(mk(2'b11, 0, 3'd2, 32'h28, 32'h0));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h400, 32'h0));
            tq.push_back(mk(2'b10, 1, 3'd2, 32'h02, 32'h55555555));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h00, 32'h0));
            tq.push_back(mk(2'b10, 1, 3'd2, 32'h40, 32'hCAFEF00D));
            tq.push_back(mk(2'b10, 0, 3'd2, 32'h40, 32'h0));
            run(d);
            check($sformatf("plan_model d%0d", d), 64'(mread(d, 32'h10)), 64'hAA225566);

            for (int k = 0; k < 80; k++) tq.push_back(rnd_xfer());
            run(d);
        end

        // Reset lands in the second wait cycle of a write; memory must keep the old word.
        w = mk(2'b10, 1, 3'd2, 32'h50, 32'h0BAD0BAD);
        drive(1, w);
        @(posedge clk); #1;
        drive(1, idle);
        hwdata[1] = 32'h0BAD0BAD;
        @(negedge clk);
        check("rst_w1", 64'(obs(1)), 64'h0);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("rst_w2", 64'(obs(1)), 64'h0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("rst_out", 64'(obs(1)), {30'h0, 34'h2_0000_0000});
        @(posedge clk); #1;
        tq.push_back(mk(2'b10, 0, 3'd2, 32'h50, 32'h0));
        run(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
